// File: rtl/id_issue.sv
// RV32I decode/issue stage for OP, OP-IMM and LUI.
//
// Fetch handshake: an instruction is consumed on a rising edge when
// if_valid_i && if_ready_o. if_ready_o is combinational and drops under reset,
// stall, flush or a load-use hazard. There is no downstream ready. stall_i
// freezes the issued bundle, and valid_o marks a bundle that execute should use.
//
// The issued bundle is registered. An accepted instruction therefore shows up
// on the outputs exactly one cycle after it is consumed.
module id_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] inst_i,
  output logic        rf_re1_o,
  output logic        rf_re2_o,
  output logic [4:0]  rf_raddr1_o,
  output logic [4:0]  rf_raddr2_o,
  input  logic [31:0] rf_rdata1_i,
  input  logic [31:0] rf_rdata2_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_load_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [7:0]  aluop_o,
  output logic [2:0]  alusel_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic        valid_o,
  output logic        illegal_o
);

  // Opcodes
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  // funct7 values that are meaningful
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes shared with execute
  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20;
  localparam logic [7:0] EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
  localparam logic [7:0] EXE_SLTI_OP  = 8'h57;
  localparam logic [7:0] EXE_SLTIU_OP = 8'h58;
  localparam logic [7:0] EXE_ANDI_OP  = 8'h59;
  localparam logic [7:0] EXE_ORI_OP   = 8'h5A;
  localparam logic [7:0] EXE_XORI_OP  = 8'h5B;
  localparam logic [7:0] EXE_SLLI_OP  = 8'h5C;
  localparam logic [7:0] EXE_SRLI_OP  = 8'h5D;
  localparam logic [7:0] EXE_SRAI_OP  = 8'h5E;

  // Result selectors
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_sext;
  logic [31:0] shamt_zext;
  logic [31:0] lui_imm;

  assign opcode     = inst_i[6:0];
  assign rd         = inst_i[11:7];
  assign funct3     = inst_i[14:12];
  assign rs1        = inst_i[19:15];
  assign rs2        = inst_i[24:20];
  assign funct7     = inst_i[31:25];
  assign imm_sext   = {{20{inst_i[31]}}, inst_i[31:20]};
  assign shamt_zext = {27'd0, inst_i[24:20]};
  assign lui_imm    = {inst_i[31:12], 12'd0};

  // Register-file reads follow the opcode whenever fetch offers an instruction
  logic is_op;
  logic is_opimm;

  assign is_op       = (opcode == OPC_OP);
  assign is_opimm    = (opcode == OPC_OPIMM);
  assign rf_re1_o    = if_valid_i & (is_op | is_opimm);
  assign rf_re2_o    = if_valid_i & is_op;
  assign rf_raddr1_o = rf_re1_o ? rs1 : 5'd0;
  assign rf_raddr2_o = rf_re2_o ? rs2 : 5'd0;

  // A load in EX whose destination we read cannot be forwarded yet
  logic hazard;
  logic ex_hit1;
  logic ex_hit2;

  assign ex_hit1    = rf_re1_o & (ex_wd_i == rs1);
  assign ex_hit2    = rf_re2_o & (ex_wd_i == rs2);
  assign hazard     = ex_load_i & ex_wreg_i & (ex_wd_i != 5'd0) & (ex_hit1 | ex_hit2);
  assign if_ready_o = ~rst & ~stall_i & ~flush_i & ~hazard;

  // Operand resolution: x0, then the younger EX result, then MEM, then the register file
  logic [31:0] opnd1;
  logic [31:0] opnd2;

  // Forwarding mux for rs1
  always_comb begin
    opnd1 = rf_rdata1_i;
    if (rs1 == 5'd0) begin
      opnd1 = 32'd0;
    end else if (ex_wreg_i && (ex_wd_i == rs1)) begin
      opnd1 = ex_wdata_i;
    end else if (mem_wreg_i && (mem_wd_i == rs1)) begin
      opnd1 = mem_wdata_i;
    end
  end

  // Forwarding mux for rs2
  always_comb begin
    opnd2 = rf_rdata2_i;
    if (rs2 == 5'd0) begin
      opnd2 = 32'd0;
    end else if (ex_wreg_i && (ex_wd_i == rs2)) begin
      opnd2 = ex_wdata_i;
    end else if (mem_wreg_i && (mem_wd_i == rs2)) begin
      opnd2 = mem_wdata_i;
    end
  end

  // Decoded bundle for the instruction currently on inst_i
  logic [7:0]  dec_aluop;
  logic [2:0]  dec_alusel;
  logic [31:0] dec_reg1;
  logic [31:0] dec_reg2;
  logic        dec_illegal;

  // Instruction decode into ALU op, selector and operands
  always_comb begin
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_reg1    = 32'd0;
    dec_reg2    = 32'd0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        dec_reg1 = opnd1;
        dec_reg2 = imm_sext;
        case (funct3)
          3'b000: begin dec_aluop = EXE_ADDI_OP;  dec_alusel = EXE_RES_ARITH; end
          3'b010: begin dec_aluop = EXE_SLTI_OP;  dec_alusel = EXE_RES_ARITH; end
          // Immediate stays sign-extended; execute performs the unsigned compare
          3'b011: begin dec_aluop = EXE_SLTIU_OP; dec_alusel = EXE_RES_ARITH; end
          3'b100: begin dec_aluop = EXE_XORI_OP;  dec_alusel = EXE_RES_LOGIC; end
          3'b110: begin dec_aluop = EXE_ORI_OP;   dec_alusel = EXE_RES_LOGIC; end
          3'b111: begin dec_aluop = EXE_ANDI_OP;  dec_alusel = EXE_RES_LOGIC; end
          3'b001: begin
            dec_reg2 = shamt_zext;
            if (funct7 == F7_BASE) begin
              dec_aluop  = EXE_SLLI_OP;
              dec_alusel = EXE_RES_SHIFT;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: begin
            // funct3 101: logical or arithmetic right shift by immediate
            dec_reg2 = shamt_zext;
            if (funct7 == F7_BASE) begin
              dec_aluop  = EXE_SRLI_OP;
              dec_alusel = EXE_RES_SHIFT;
            end else if (funct7 == F7_ALT) begin
              dec_aluop  = EXE_SRAI_OP;
              dec_alusel = EXE_RES_SHIFT;
            end else begin
              dec_illegal = 1'b1;
            end
          end
        endcase
      end
      OPC_OP: begin
        dec_reg1 = opnd1;
        dec_reg2 = opnd2;
        if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  begin dec_aluop = EXE_SUB_OP; dec_alusel = EXE_RES_ARITH; end
            3'b101:  begin dec_aluop = EXE_SRA_OP; dec_alusel = EXE_RES_SHIFT; end
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  begin dec_aluop = EXE_ADD_OP;   dec_alusel = EXE_RES_ARITH; end
            3'b001:  begin dec_aluop = EXE_SLL_OP;   dec_alusel = EXE_RES_SHIFT; end
            3'b010:  begin dec_aluop = EXE_SLT_OP;   dec_alusel = EXE_RES_ARITH; end
            // SLTU shares the unsigned-compare op with SLTIU
            3'b011:  begin dec_aluop = EXE_SLTIU_OP; dec_alusel = EXE_RES_ARITH; end
            3'b100:  begin dec_aluop = EXE_XOR_OP;   dec_alusel = EXE_RES_LOGIC; end
            3'b101:  begin dec_aluop = EXE_SRL_OP;   dec_alusel = EXE_RES_SHIFT; end
            3'b110:  begin dec_aluop = EXE_OR_OP;    dec_alusel = EXE_RES_LOGIC; end
            default: begin dec_aluop = EXE_AND_OP;   dec_alusel = EXE_RES_LOGIC; end
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_reg1 = lui_imm;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Issued bundle registers
  logic [7:0]  aluop_q,   aluop_d;
  logic [2:0]  alusel_q,  alusel_d;
  logic [31:0] reg1_q,    reg1_d;
  logic [31:0] reg2_q,    reg2_d;
  logic [4:0]  wd_q,      wd_d;
  logic        wreg_q,    wreg_d;
  logic        valid_q,   valid_d;
  logic        illegal_q, illegal_d;

  // Next bundle: flush, then stall (hold), then hazard / no input / illegal (bubble), else issue
  always_comb begin
    aluop_d   = aluop_q;
    alusel_d  = alusel_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    if (flush_i || (!stall_i && (hazard || !if_valid_i || dec_illegal))) begin
      aluop_d  = EXE_NOP_OP;
      alusel_d = EXE_RES_NOP;
      reg1_d   = 32'd0;
      reg2_d   = 32'd0;
      wd_d     = 5'd0;
      wreg_d   = 1'b0;
      valid_d  = 1'b0;
      // Only a consumed instruction can be reported as illegal
      illegal_d = !flush_i && !hazard && if_valid_i && dec_illegal;
    end else if (!stall_i) begin
      aluop_d  = dec_aluop;
      alusel_d = dec_alusel;
      reg1_d   = dec_reg1;
      reg2_d   = dec_reg2;
      wd_d     = rd;
      wreg_d   = (rd != 5'd0);
      valid_d  = 1'b1;
    end
  end

  // Bundle state with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q   <= EXE_NOP_OP;
      alusel_q  <= EXE_RES_NOP;
      reg1_q    <= 32'd0;
      reg2_q    <= 32'd0;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign aluop_o   = aluop_q;
  assign alusel_o  = alusel_q;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;
  assign wd_o      = wd_q;
  assign wreg_o    = wreg_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_id_issue.sv
// Bench for id_issue: directed scenarios followed by random traffic, with a
// reference model predicting every registered bundle into a scoreboard queue.
module tb_id_issue;

  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20;
  localparam logic [7:0] EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
  localparam logic [7:0] EXE_SLTI_OP  = 8'h57;
  localparam logic [7:0] EXE_SLTIU_OP = 8'h58;
  localparam logic [7:0] EXE_ANDI_OP  = 8'h59;
  localparam logic [7:0] EXE_ORI_OP   = 8'h5A;
  localparam logic [7:0] EXE_XORI_OP  = 8'h5B;
  localparam logic [7:0] EXE_SLLI_OP  = 8'h5C;
  localparam logic [7:0] EXE_SRLI_OP  = 8'h5D;
  localparam logic [7:0] EXE_SRAI_OP  = 8'h5E;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        valid;
    logic        illegal;
  } bundle_t;

  logic        clk;
  logic        rst;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] inst_i;
  logic        rf_re1_o, rf_re2_o;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic        ex_wreg_i, ex_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        stall_i, flush_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o, valid_o, illegal_o;

  logic [31:0] rf_mem [32];
  bundle_t     exp_q [$];
  int          total;
  int          bad;

  id_issue dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .inst_i(inst_i),
    .rf_re1_o(rf_re1_o), .rf_re2_o(rf_re2_o),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .valid_o(valid_o), .illegal_o(illegal_o)
  );

  // Behavioural register file: combinational read
  assign rf_rdata1_i = rf_mem[rf_raddr1_o];
  assign rf_rdata2_i = rf_mem[rf_raddr2_o];

  // Clock and reset-time defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic bundle_t bubble();
    bundle_t b;
    b = '0;
    b.aluop  = EXE_NOP_OP;
    b.alusel = EXE_RES_NOP;
    return b;
  endfunction

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    if (op == EXE_ADD_OP || op == EXE_SUB_OP || op == EXE_SLT_OP ||
        op == EXE_ADDI_OP || op == EXE_SLTI_OP || op == EXE_SLTIU_OP)
      return EXE_RES_ARITH;
    if (op == EXE_AND_OP || op == EXE_OR_OP || op == EXE_XOR_OP ||
        op == EXE_ANDI_OP || op == EXE_ORI_OP || op == EXE_XORI_OP)
      return EXE_RES_LOGIC;
    if (op == EXE_NOP_OP)
      return EXE_RES_NOP;
    return EXE_RES_SHIFT;
  endfunction

  // Youngest producer wins: EX before MEM before the register file
  function automatic logic [31:0] resolve(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (ex_wreg_i && ex_wd_i == rs) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == rs) return mem_wdata_i;
    return rf_mem[rs];
  endfunction

  function automatic bundle_t model_decode(input logic [31:0] inst);
    bundle_t     b;
    logic        ok;
    logic [7:0]  op;
    logic [31:0] simm;
    logic [31:0] shamt;
    b     = bubble();
    ok    = 1'b1;
    op    = EXE_NOP_OP;
    simm  = {{20{inst[31]}}, inst[31:20]};
    shamt = {27'd0, inst[24:20]};
    case (inst[6:0])
      7'b0010011: begin
        b.reg1 = resolve(inst[19:15]);
        b.reg2 = simm;
        case (inst[14:12])
          3'd0: op = EXE_ADDI_OP;
          3'd2: op = EXE_SLTI_OP;
          3'd3: op = EXE_SLTIU_OP;
          3'd4: op = EXE_XORI_OP;
          3'd6: op = EXE_ORI_OP;
          3'd7: op = EXE_ANDI_OP;
          3'd1: begin b.reg2 = shamt; ok = (inst[31:25] == 7'h00); op = EXE_SLLI_OP; end
          default: begin
            b.reg2 = shamt;
            if (inst[31:25] == 7'h00) op = EXE_SRLI_OP;
            else if (inst[31:25] == 7'h20) op = EXE_SRAI_OP;
            else ok = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        b.reg1 = resolve(inst[19:15]);
        b.reg2 = resolve(inst[24:20]);
        case ({inst[31:25], inst[14:12]})
          {7'h00, 3'd0}: op = EXE_ADD_OP;
          {7'h00, 3'd1}: op = EXE_SLL_OP;
          {7'h00, 3'd2}: op = EXE_SLT_OP;
          {7'h00, 3'd3}: op = EXE_SLTIU_OP;
          {7'h00, 3'd4}: op = EXE_XOR_OP;
          {7'h00, 3'd5}: op = EXE_SRL_OP;
          {7'h00, 3'd6}: op = EXE_OR_OP;
          {7'h00, 3'd7}: op = EXE_AND_OP;
          {7'h20, 3'd0}: op = EXE_SUB_OP;
          {7'h20, 3'd5}: op = EXE_SRA_OP;
          default:       ok = 1'b0;
        endcase
      end
      7'b0110111: b.reg1 = {inst[31:12], 12'd0};
      default:    ok = 1'b0;
    endcase
    if (!ok) begin
      b = bubble();
      b.illegal = 1'b1;
      return b;
    end
    b.aluop  = op;
    b.alusel = sel_of(op);
    b.wd     = inst[11:7];
    b.wreg   = (inst[11:7] != 5'd0);
    b.valid  = 1'b1;
    return b;
  endfunction

  bundle_t model_q;

  // ---------------- driver ----------------
  // Inputs are set by the caller; this checks ready, predicts the next bundle and clocks once.
  task automatic step();
    bundle_t nxt;
    logic    rd1, rd2, hz, rdy;
    #1;
    rd1 = if_valid_i && (inst_i[6:0] == 7'b0110011 || inst_i[6:0] == 7'b0010011);
    rd2 = if_valid_i && (inst_i[6:0] == 7'b0110011);
    hz  = ex_load_i && ex_wreg_i && ex_wd_i != 5'd0 &&
          ((rd1 && ex_wd_i == inst_i[19:15]) || (rd2 && ex_wd_i == inst_i[24:20]));
    rdy = !rst && !stall_i && !flush_i && !hz;
    total++;
    if (if_ready_o !== rdy) begin
      bad++;
      $display("FAIL if_ready t=%0t got=%b exp=%b", $time, if_ready_o, rdy);
    end
    if (rst)                 nxt = bubble();
    else if (flush_i)        nxt = bubble();
    else if (stall_i)        begin nxt = model_q; nxt.illegal = 1'b0; end
    else if (hz || !if_valid_i) nxt = bubble();
    else                     nxt = model_decode(inst_i);
    exp_q.push_back(nxt);
    model_q = nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle_fwd();
    ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'd0; ex_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'd0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  f7;
    int          k;
    k  = $urandom_range(0, 9);
    f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
    w  = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    if (k <= 3) begin
      w[6:0] = 7'b0010011;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
        w[31:25] = f7;
        w[24:20] = 5'($urandom);
      end
    end else if (k <= 6) begin
      w[6:0]   = 7'b0110011;
      w[31:25] = f7;
      w[24:20] = 5'($urandom_range(0, 7));
    end else if (k == 7) begin
      w[6:0] = 7'b0110111;
    end else if (k == 9) begin
      w[6:0]   = 7'b0110011;
      w[31:25] = 7'h00;
      w[11:7]  = 5'd0;
    end
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bundle_t e;
    bundle_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, valid_o, illegal_o};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL bundle t=%0t got op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b v=%b ill=%b exp op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b v=%b ill=%b",
                   $time, got.aluop, got.alusel, got.reg1, got.reg2, got.wd, got.wreg, got.valid, got.illegal,
                   e.aluop, e.alusel, e.reg1, e.reg2, e.wd, e.wreg, e.valid, e.illegal);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    model_q = bubble();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rst = 1'b1; if_valid_i = 1'b1; inst_i = 32'h00500093;
    stall_i = 1'b0; flush_i = 1'b0;
    idle_fwd();
    @(posedge clk);
    #2;

    // Reset held two cycles with an instruction offered
    step();
    step();
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_aluop", 32'(aluop_o), 32'(EXE_NOP_OP));
    rst = 1'b0;

    // ADDI x1, x0, 5
    step();
    chk("addi_op", 32'(aluop_o), 32'(EXE_ADDI_OP));
    chk("addi_sel", 32'(alusel_o), 32'(EXE_RES_ARITH));
    chk("addi_reg2", reg2_o, 32'd5);
    chk("addi_wd", 32'(wd_o), 32'd1);

    // Stall three cycles while something else is offered: bundle holds
    stall_i = 1'b1; inst_i = 32'h002081B3;
    for (int i = 0; i < 3; i++) step();
    chk("stall_hold_reg2", reg2_o, 32'd5);
    chk("stall_hold_valid", 32'(valid_o), 32'd1);
    flush_i = 1'b1;
    step();
    chk("flush_in_stall", 32'(valid_o), 32'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // Forwarding priority on add x3, x1, x2
    rf_mem[1] = 32'd0; rf_mem[2] = 32'h22;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'd7;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'd9;
    step();
    chk("fwd_ex_reg1", reg1_o, 32'd7);
    chk("fwd_rf_reg2", reg2_o, 32'h22);
    ex_wreg_i = 1'b0;
    step();
    chk("fwd_mem_reg1", reg1_o, 32'd9);

    // Load-use on x1, then the load resolves
    ex_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd1;
    step();
    chk("loaduse_bubble", 32'(valid_o), 32'd0);
    ex_load_i = 1'b0;
    step();
    chk("loaduse_release", 32'(valid_o), 32'd1);
    idle_fwd();

    // SRAI x5, x6, 3 and a bad-funct7 variant
    inst_i = 32'h40335293;
    step();
    chk("srai_op", 32'(aluop_o), 32'(EXE_SRAI_OP));
    chk("srai_reg2", reg2_o, 32'd3);
    chk("srai_wd", 32'(wd_o), 32'd5);
    inst_i = 32'h20335293;
    step();
    chk("illegal_pulse", 32'(illegal_o), 32'd1);
    chk("illegal_valid", 32'(valid_o), 32'd0);
    if_valid_i = 1'b0;
    step();
    chk("illegal_one_cycle", 32'(illegal_o), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 49) == 0);
      if_valid_i  = ($urandom_range(0, 3) != 0);
      inst_i      = rand_inst();
      stall_i     = ($urandom_range(0, 5) == 0);
      flush_i     = ($urandom_range(0, 11) == 0);
      ex_load_i   = ($urandom_range(0, 3) == 0);
      ex_wreg_i   = ($urandom_range(0, 1) == 0);
      ex_wd_i     = 5'($urandom_range(0, 7));
      ex_wdata_i  = $urandom;
      mem_wreg_i  = ($urandom_range(0, 1) == 0);
      mem_wd_i    = 5'($urandom_range(0, 7));
      mem_wdata_i = $urandom;
      if ($urandom_range(0, 15) == 0) rf_mem[$urandom_range(1, 7)] = $urandom;
      step();
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
